jt900h_busarb: RTL and testbench

//  Shares the single 16-bit external memory bus between the jt900h CPU core and one DMA requester.

---
 rtl/jt900h_busarb.sv | 160 ++++++++++++++++
 tb/tb_jt900h_busarb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt900h_busarb.sv
// Arbiter sharing the 16-bit external bus between the jt900h CPU and one DMA requester.
// DMA has priority with a bounded burst; a watchdog aborts accesses that never see mem_ok.
module jt900h_busarb #(
    parameter int unsigned DMA_BURST = 4,
    parameter int unsigned TOUT      = 255
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        cpu_cs,
    input  logic [23:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic [1:0]  cpu_we,
    output logic [15:0] cpu_din,
    output logic        cpu_busy,
    input  logic        dma_req,
    input  logic [23:0] dma_addr,
    input  logic [15:0] dma_dout,
    input  logic [1:0]  dma_we,
    output logic [15:0] dma_din,
    output logic        dma_ack,
    output logic        mem_cs,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_dout,
    output logic [1:0]  mem_we,
    input  logic [15:0] mem_din,
    input  logic        mem_ok,
    output logic        bus_err
);
    localparam int unsigned BW = 4;
    localparam int unsigned WW = 8;
    localparam logic [BW-1:0] BURST_MAX = BW'(DMA_BURST);
    localparam logic [WW-1:0] WD_LAST   = WW'(TOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_DMA  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          mem_cs_q, mem_cs_d;
    logic [23:0]   mem_addr_q, mem_addr_d;
    logic [15:0]   mem_dout_q, mem_dout_d;
    logic [1:0]    mem_we_q, mem_we_d;
    logic [15:0]   cpu_din_q, cpu_din_d;
    logic [15:0]   dma_din_q, dma_din_d;
    logic          cpu_done_q, cpu_done_d;
    logic          dma_ack_q, dma_ack_d;
    logic          bus_err_q, bus_err_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic [15:0]   rdata;

    // Next-state: arbitration in IDLE, completion or watchdog abort in the owner states
    always_comb begin
        state_d     = state_q;
        mem_cs_d    = mem_cs_q;
        mem_addr_d  = mem_addr_q;
        mem_dout_d  = mem_dout_q;
        mem_we_d    = mem_we_q;
        cpu_din_d   = cpu_din_q;
        dma_din_d   = dma_din_q;
        cpu_done_d  = cpu_done_q;
        dma_ack_d   = dma_ack_q;
        bus_err_d   = bus_err_q;
        burst_cnt_d = burst_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        rdata       = mem_ok ? mem_din : 16'hFFFF;
        if (cen) begin
            cpu_done_d = 1'b0;
            dma_ack_d  = 1'b0;
            bus_err_d  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dma_req && (!cpu_cs || burst_cnt_q < BURST_MAX)) begin
                        state_d     = ST_DMA;
                        burst_cnt_d = cpu_cs ? BW'(burst_cnt_q + 1'b1) : '0;
                        mem_cs_d    = 1'b1;
                        mem_addr_d  = dma_addr;
                        mem_dout_d  = dma_dout;
                        mem_we_d    = dma_we;
                        wd_cnt_d    = '0;
                    end else if (cpu_cs) begin
                        state_d     = ST_CPU;
                        burst_cnt_d = '0;
                        mem_cs_d    = 1'b1;
                        mem_addr_d  = cpu_addr;
                        mem_dout_d  = cpu_dout;
                        mem_we_d    = cpu_we;
                        wd_cnt_d    = '0;
                    end else begin
                        burst_cnt_d = '0;
                    end
                end
                ST_CPU, ST_DMA: begin
                    if (mem_ok || wd_cnt_q == WD_LAST) begin
                        if (state_q == ST_CPU) begin
                            cpu_din_d  = rdata;
                            cpu_done_d = 1'b1;
                        end else begin
                            dma_din_d = rdata;
                            dma_ack_d = 1'b1;
                        end
                        bus_err_d = ~mem_ok;
                        mem_cs_d  = 1'b0;
                        mem_we_d  = 2'b00;
                        state_d   = ST_IDLE;
                    end else begin
                        wd_cnt_d = WW'(wd_cnt_q + 1'b1);
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    mem_cs_d = 1'b0;
                    mem_we_d = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_cs_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
            mem_we_q    <= 2'b00;
            cpu_din_q   <= '0;
            dma_din_q   <= '0;
            cpu_done_q  <= 1'b0;
            dma_ack_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            burst_cnt_q <= '0;
            wd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_cs_q    <= mem_cs_d;
            mem_addr_q  <= mem_addr_d;
            mem_dout_q  <= mem_dout_d;
            mem_we_q    <= mem_we_d;
            cpu_din_q   <= cpu_din_d;
            dma_din_q   <= dma_din_d;
            cpu_done_q  <= cpu_done_d;
            dma_ack_q   <= dma_ack_d;
            bus_err_q   <= bus_err_d;
            burst_cnt_q <= burst_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    assign cpu_busy = cpu_cs & ~cpu_done_q;
    assign cpu_din  = cpu_din_q;
    assign dma_din  = dma_din_q;
    assign dma_ack  = dma_ack_q;
    assign mem_cs   = mem_cs_q;
    assign mem_addr = mem_addr_q;
    assign mem_dout = mem_dout_q;
    assign mem_we   = mem_we_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_jt900h_busarb.sv
// Directed bench for jt900h_busarb with DMA_BURST=4, TOUT=8.
module tb_jt900h_busarb;
    logic        clk = 1'b0;
    logic        rst, cen;
    logic        cpu_cs, cpu_busy, dma_req, dma_ack, mem_cs, mem_ok, bus_err;
    logic [23:0] cpu_addr, dma_addr, mem_addr;
    logic [15:0] cpu_dout, cpu_din, dma_dout, dma_din, mem_dout, mem_din;
    logic [1:0]  cpu_we, dma_we, mem_we;

    int total = 0;
    int bad   = 0;
    int ngrant, nack, ndone, nerr, cnt_hi;
    logic prev_cs;
    int exp_dma[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    localparam logic [23:0] DMA_A = 24'h100000;
    localparam logic [23:0] CPU_A = 24'h200000;

    jt900h_busarb #(.DMA_BURST(4), .TOUT(8)) dut (
        .rst(rst), .clk(clk), .cen(cen),
        .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
        .cpu_din(cpu_din), .cpu_busy(cpu_busy),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_we(dma_we),
        .dma_din(dma_din), .dma_ack(dma_ack),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we),
        .mem_din(mem_din), .mem_ok(mem_ok), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; cen = 1'b1;
        cpu_cs = 1'b0; cpu_addr = '0; cpu_dout = '0; cpu_we = 2'b00;
        dma_req = 1'b0; dma_addr = '0; dma_dout = '0; dma_we = 2'b00;
        mem_din = '0; mem_ok = 1'b0;
        step(); step();
        check("rst_mem_cs",   32'(mem_cs), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_we",   32'(mem_we), 32'h0);
        check("rst_cpu_din",  32'(cpu_din), 32'h0);
        check("rst_dma_ack",  32'(dma_ack), 32'h0);
        check("rst_bus_err",  32'(bus_err), 32'h0);
        check("rst_cpu_busy", 32'(cpu_busy), 32'h0);
        rst = 1'b0;
        step();

        // CPU-only reads; memory answers one cycle after mem_cs, CPU idles one cycle between reads
        cpu_cs = 1'b1; cpu_addr = 24'hFF1800;
        #1 check("t1_busy_req", 32'(cpu_busy), 32'h1);
        step();
        check("t1_grant_cs",   32'(mem_cs), 32'h1);
        check("t1_grant_addr", 32'(mem_addr), 32'h00FF1800);
        check("t1_grant_busy", 32'(cpu_busy), 32'h1);
        step();
        check("t1_wait_cs", 32'(mem_cs), 32'h1);
        mem_ok = 1'b1; mem_din = 16'h1234;
        step();
        check("t1_done_cs",   32'(mem_cs), 32'h0);
        check("t1_done_busy", 32'(cpu_busy), 32'h0);
        check("t1_done_din",  32'(cpu_din), 32'h1234);
        cpu_cs = 1'b0; mem_ok = 1'b0;
        step();
        check("t1_idle1_cs", 32'(mem_cs), 32'h0);
        cpu_cs = 1'b1; cpu_addr = 24'hFF1802;
        step();
        check("t1_idle2_busy", 32'(cpu_busy), 32'h1);
        check("t1_rd2_cs",     32'(mem_cs), 32'h1);
        check("t1_rd2_addr",   32'(mem_addr), 32'h00FF1802);
        step();
        mem_ok = 1'b1; mem_din = 16'hBEEF;
        step();
        check("t1_rd2_busy", 32'(cpu_busy), 32'h0);
        check("t1_rd2_din",  32'(cpu_din), 32'hBEEF);
        cpu_cs = 1'b0; mem_ok = 1'b0;
        step();

        // Both requesters continuous, zero-wait memory: DMA x4 then CPU
        cpu_addr = CPU_A; dma_addr = DMA_A; cpu_cs = 1'b1; dma_req = 1'b1;
        ngrant = 0; nack = 0; ndone = 0; prev_cs = 1'b0;
        for (int i = 0; i < 200 && ngrant < 10; i++) begin
            step();
            if (dma_ack) nack++;
            if (cpu_done_seen()) ndone++;
            if (mem_cs && !prev_cs) begin
                check($sformatf("t2_grant%0d", ngrant), 32'(mem_addr == DMA_A), 32'(exp_dma[ngrant]));
                ngrant++;
            end
            prev_cs = mem_cs;
            mem_ok = mem_cs;
        end
        check("t2_grants", 32'(ngrant), 32'd10);
        check("t2_acks",   32'(nack), 32'd8);
        check("t2_dones",  32'(ndone), 32'd1);
        cpu_cs = 1'b0; dma_req = 1'b0;
        step();
        mem_ok = 1'b0;
        step();
        check("t2_end_cs", 32'(mem_cs), 32'h0);

        // Watchdog: mem_ok never arrives
        cpu_cs = 1'b1; cpu_addr = 24'h300000;
        step();
        cnt_hi = mem_cs ? 1 : 0;
        nerr = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus_err) nerr++;
            if (!mem_cs) break;
            cnt_hi++;
        end
        check("t3_cs_cycles", 32'(cnt_hi), 32'd8);
        check("t3_bus_err",   32'(bus_err), 32'h1);
        check("t3_cpu_din",   32'(cpu_din), 32'hFFFF);
        check("t3_busy",      32'(cpu_busy), 32'h0);
        cpu_cs = 1'b0;
        step();
        if (bus_err) nerr++;
        check("t3_err_pulses", 32'(nerr), 32'd1);
        cpu_cs = 1'b1; cpu_addr = 24'h300002;
        step();
        check("t3_next_addr", 32'(mem_addr), 32'h00300002);
        mem_ok = 1'b1; mem_din = 16'h5A5A;
        step();
        check("t3_next_din", 32'(cpu_din), 32'h5A5A);
        check("t3_next_err", 32'(bus_err), 32'h0);
        cpu_cs = 1'b0; mem_ok = 1'b0;
        step();

        // cen toggling during a DMA byte write
        dma_req = 1'b1; dma_addr = 24'h400000; dma_we = 2'b01; dma_dout = 16'h00A5;
        step();
        check("t4_we",   32'(mem_we), 32'h1);
        check("t4_dout", 32'(mem_dout), 32'h00A5);
        dma_dout = 16'h1111; dma_we = 2'b11;
        cen = 1'b0; mem_ok = 1'b1;
        step();
        check("t4_cen0_cs",   32'(mem_cs), 32'h1);
        check("t4_cen0_ack",  32'(dma_ack), 32'h0);
        check("t4_cen0_dout", 32'(mem_dout), 32'h00A5);
        cen = 1'b1; mem_ok = 1'b0;
        step();
        cen = 1'b0;
        step();
        check("t4_hold_we", 32'(mem_we), 32'h1);
        cen = 1'b1; mem_ok = 1'b1; mem_din = 16'h7E7E;
        step();
        check("t4_ack",     32'(dma_ack), 32'h1);
        check("t4_done_cs", 32'(mem_cs), 32'h0);
        check("t4_done_we", 32'(mem_we), 32'h0);
        check("t4_dma_din", 32'(dma_din), 32'h7E7E);
        dma_req = 1'b0; cen = 1'b0; mem_ok = 1'b0;
        step();
        check("t4_ack_hold", 32'(dma_ack), 32'h1);
        cen = 1'b1;
        step();
        check("t4_ack_clr", 32'(dma_ack), 32'h0);

        // Reset in the middle of a DMA access with a CPU request pending
        dma_we = 2'b00; dma_req = 1'b1; dma_addr = 24'h500000;
        cpu_cs = 1'b1; cpu_addr = 24'h600000;
        step();
        check("t5_dma_addr", 32'(mem_addr), 32'h00500000);
        rst = 1'b1;
        step();
        check("t5_rst_cs",  32'(mem_cs), 32'h0);
        check("t5_rst_ack", 32'(dma_ack), 32'h0);
        rst = 1'b0; dma_req = 1'b0;
        step();
        check("t5_cpu_cs",   32'(mem_cs), 32'h1);
        check("t5_cpu_addr", 32'(mem_addr), 32'h00600000);
        mem_ok = 1'b1; mem_din = 16'h1111;
        step();
        check("t5_cpu_din", 32'(cpu_din), 32'h1111);
        cpu_cs = 1'b0; mem_ok = 1'b0;
        step();

        // DMA request withdrawn after grant
        dma_req = 1'b1; dma_addr = 24'h700000;
        step();
        dma_req = 1'b0;
        step();
        check("t6_wait_cs", 32'(mem_cs), 32'h1);
        mem_ok = 1'b1;
        step();
        check("t6_ack",     32'(dma_ack), 32'h1);
        check("t6_done_cs", 32'(mem_cs), 32'h0);
        mem_ok = 1'b0;
        step();
        check("t6_ack_clr", 32'(dma_ack), 32'h0);
        step(); step();
        check("t6_no_regrant", 32'(mem_cs), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // CPU completion as visible on the ports: busy low while the request is held
    function automatic logic cpu_done_seen();
        return cpu_cs && !cpu_busy;
    endfunction

endmodule
